cordic_sweep_ctrl: RTL and testbench

//  Sequencer for the pipelined CORDIC NCO/rotator. Drives phase_step/xin/yin to step a

---
 rtl/cordic_sweep_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cordic_sweep_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sweep_ctrl.sv
// Frequency-sweep sequencer for a pipelined CORDIC NCO: steps phase_step through
// f_start + k*f_step and forwards only settled I/Q samples. Optional: SWEEP_LOOP_EN.
module cordic_sweep_ctrl #(
  parameter int PHASE_W = 32,
  parameter int AMP_W   = 16,
  parameter int OUT_W   = 22,
  parameter int CNT_W   = 16,
  parameter int LAT     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
`ifdef SWEEP_LOOP_EN
  input  logic               loop,
`endif
  input  logic [PHASE_W-1:0] f_start,
  input  logic [PHASE_W-1:0] f_step,
  input  logic [CNT_W-1:0]   n_steps,
  input  logic [CNT_W-1:0]   dwell,
  input  logic [AMP_W-1:0]   amp,
  output logic [PHASE_W-1:0] phase_step,
  output logic [AMP_W-1:0]   xin,
  output logic [AMP_W-1:0]   yin,
  input  logic [OUT_W-1:0]   xout_c,
  input  logic [OUT_W-1:0]   yout_c,
  output logic [OUT_W-1:0]   i_out,
  output logic [OUT_W-1:0]   q_out,
  output logic               iq_valid,
  output logic [CNT_W-1:0]   step_idx,
  output logic               busy,
  output logic               done
);

  localparam int LAT_W = $clog2(LAT + 1);
  localparam int CTR_W = (CNT_W > LAT_W) ? CNT_W : LAT_W;

  typedef enum logic [1:0] {IDLE, SETTLE, DWELL, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [CTR_W-1:0]   cnt;
  logic [PHASE_W-1:0] f_start_lat;
  logic [PHASE_W-1:0] f_step_lat;
  logic [CNT_W-1:0]   last_idx;
  logic [CNT_W-1:0]   dwell_last;
  logic               cnt_zero;
  logic               last_step;
  logic               loop_en;

`ifdef SWEEP_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  assign cnt_zero  = (cnt == '0);
  assign last_step = (step_idx == last_idx);
  assign yin       = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = SETTLE;
        SETTLE:  if (cnt_zero) state_next = DWELL;
        DWELL:   if (cnt_zero) state_next = (last_step && !loop_en) ? DONE : SETTLE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Config is captured at start so register writes mid-sweep cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_step  <= '0;
      xin         <= '0;
      step_idx    <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      f_start_lat <= '0;
      f_step_lat  <= '0;
      last_idx    <= '0;
      dwell_last  <= '0;
    end else if (abort) begin
      phase_step <= '0;
      xin        <= '0;
      step_idx   <= '0;
      cnt        <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            f_start_lat <= f_start;
            f_step_lat  <= f_step;
            last_idx    <= (n_steps == '0) ? '0 : n_steps - CNT_W'(1);
            dwell_last  <= (dwell == '0) ? '0 : dwell - CNT_W'(1);
            phase_step  <= f_start;
            xin         <= amp;
            step_idx    <= '0;
            cnt         <= CTR_W'(LAT - 1);
          end
        end
        SETTLE: begin
          if (cnt_zero) cnt <= CTR_W'(dwell_last);
          else          cnt <= cnt - CTR_W'(1);
        end
        DWELL: begin
          if (cnt_zero) begin
            if (last_step) begin
              // done is registered so it also pulses on a loop wrap, not only in DONE.
              done <= 1'b1;
              if (loop_en) begin
                phase_step <= f_start_lat;
                step_idx   <= '0;
                cnt        <= CTR_W'(LAT - 1);
              end
            end else begin
              phase_step <= phase_step + f_step_lat;
              step_idx   <= step_idx + CNT_W'(1);
              cnt        <= CTR_W'(LAT - 1);
            end
          end else begin
            cnt <= cnt - CTR_W'(1);
          end
        end
        DONE: begin
          xin <= '0;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iq_valid <= 1'b0;
      i_out    <= '0;
      q_out    <= '0;
    end else begin
      iq_valid <= (state == DWELL);
      i_out    <= xout_c;
      q_out    <= yout_c;
    end
  end

endmodule

// File: tb/tb_cordic_sweep_ctrl.sv
// Directed self-checking bench for cordic_sweep_ctrl (LAT=18); loop test only with SWEEP_LOOP_EN.
module tb_cordic_sweep_ctrl;
  localparam int PHASE_W = 32;
  localparam int AMP_W   = 16;
  localparam int OUT_W   = 22;
  localparam int CNT_W   = 16;
  localparam int LAT     = 18;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               abort;
  logic               loop;
  logic [PHASE_W-1:0] f_start;
  logic [PHASE_W-1:0] f_step;
  logic [CNT_W-1:0]   n_steps;
  logic [CNT_W-1:0]   dwell;
  logic [AMP_W-1:0]   amp;
  logic [PHASE_W-1:0] phase_step;
  logic [AMP_W-1:0]   xin;
  logic [AMP_W-1:0]   yin;
  logic [OUT_W-1:0]   xout_c;
  logic [OUT_W-1:0]   yout_c;
  logic [OUT_W-1:0]   i_out;
  logic [OUT_W-1:0]   q_out;
  logic               iq_valid;
  logic [CNT_W-1:0]   step_idx;
  logic               busy;
  logic               done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [PHASE_W-1:0] ph_log   [0:159];
  logic [CNT_W-1:0]   idx_log  [0:159];
  logic [AMP_W-1:0]   xin_log  [0:159];
  logic               val_log  [0:159];
  logic               done_log [0:159];
  logic               busy_log [0:159];

  always #5 clk = ~clk;

  cordic_sweep_ctrl #(
    .PHASE_W(PHASE_W), .AMP_W(AMP_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
`ifdef SWEEP_LOOP_EN
    .loop(loop),
`endif
    .f_start(f_start), .f_step(f_step), .n_steps(n_steps), .dwell(dwell), .amp(amp),
    .phase_step(phase_step), .xin(xin), .yin(yin), .xout_c(xout_c), .yout_c(yout_c),
    .i_out(i_out), .q_out(q_out), .iq_valid(iq_valid), .step_idx(step_idx),
    .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rec(input int e);
    ph_log[e]   = phase_step;
    idx_log[e]  = step_idx;
    xin_log[e]  = xin;
    val_log[e]  = iq_valid;
    done_log[e] = done;
    busy_log[e] = busy;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic int count_valid(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (val_log[i]) n++;
    return n;
  endfunction

  function automatic int count_done(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (done_log[i]) n++;
    return n;
  endfunction

  function automatic int count_busy(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (busy_log[i]) n++;
    return n;
  endfunction

  function automatic int first_valid(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) if (val_log[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0d expected 0", busy); else pass_cnt++;
    total_cnt++; if (phase_step !== '0) $display("FAIL reset_phase: got %h expected 0", phase_step); else pass_cnt++;
    total_cnt++; if (xin !== '0 || yin !== '0) $display("FAIL reset_xy: got %h/%h expected 0/0", xin, yin); else pass_cnt++;
    total_cnt++; if (iq_valid !== 1'b0 || done !== 1'b0) $display("FAIL reset_flags: got valid=%0d done=%0d expected 0/0", iq_valid, done); else pass_cnt++;
    total_cnt++; if (i_out !== '0 || q_out !== '0 || step_idx !== '0) $display("FAIL reset_iq: got %h/%h idx %0d expected 0", i_out, q_out, step_idx); else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_release_idle: got busy=%0d expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_output_stage();
    xout_c = 22'h35A5A5;
    yout_c = 22'h20F0F1;
    tick();
    total_cnt++; if (i_out !== 22'h35A5A5) $display("FAIL out_i: got %h expected 35a5a5", i_out); else pass_cnt++;
    total_cnt++; if (q_out !== 22'h20F0F1) $display("FAIL out_q: got %h expected 20f0f1", q_out); else pass_cnt++;
    total_cnt++; if (iq_valid !== 1'b0) $display("FAIL out_valid_idle: got %0d expected 0", iq_valid); else pass_cnt++;
  endtask

  task automatic test_single_tone();
    f_start = 32'h3555_5555; f_step = 32'h0; amp = 16'd10000; n_steps = 16'd1; dwell = 16'd8;
    pulse_start();
    rec(0);
    for (int e = 1; e <= 40; e++) begin tick(); rec(e); end
    total_cnt++; if (ph_log[0] !== 32'h3555_5555) $display("FAIL tone_phase: got %h expected 35555555", ph_log[0]); else pass_cnt++;
    total_cnt++; if (xin_log[0] !== 16'd10000) $display("FAIL tone_xin: got %0d expected 10000", xin_log[0]); else pass_cnt++;
    total_cnt++; if (count_busy(0, 40) != 27) $display("FAIL tone_busy_len: got %0d expected 27", count_busy(0, 40)); else pass_cnt++;
    total_cnt++; if (first_valid(0, 40) != 19) $display("FAIL tone_first_valid: got %0d expected 19", first_valid(0, 40)); else pass_cnt++;
    total_cnt++; if (count_valid(0, 40) != 8 || val_log[26] !== 1'b1) $display("FAIL tone_valid_cnt: got %0d (last@26=%0d) expected 8", count_valid(0, 40), val_log[26]); else pass_cnt++;
    total_cnt++; if (count_done(0, 40) != 1 || done_log[26] !== 1'b1) $display("FAIL tone_done: got %0d pulses (@26=%0d) expected 1", count_done(0, 40), done_log[26]); else pass_cnt++;
    total_cnt++; if (xin_log[27] !== '0 || xin_log[40] !== '0) $display("FAIL tone_mute: got %0d expected 0", xin_log[40]); else pass_cnt++;
    total_cnt++; if (ph_log[40] !== 32'h3555_5555) $display("FAIL tone_phase_hold: got %h expected 35555555", ph_log[40]); else pass_cnt++;
  endtask

  task automatic test_three_step();
    f_start = 32'h1000_0000; f_step = 32'hF000_0000; amp = 16'h1234; n_steps = 16'd3; dwell = 16'd4;
    pulse_start();
    f_start = 32'h0; f_step = 32'h0000_0001; n_steps = 16'd1; dwell = 16'd9;
    rec(0);
    for (int e = 1; e <= 80; e++) begin
      if (e == 5) start = 1'b1;
      tick();
      start = 1'b0;
      rec(e);
    end
    total_cnt++; if (ph_log[0] !== 32'h1000_0000 || idx_log[0] !== 16'd0) $display("FAIL sweep_step0: got %h idx %0d expected 10000000 idx 0", ph_log[0], idx_log[0]); else pass_cnt++;
    total_cnt++; if (ph_log[21] !== 32'h1000_0000) $display("FAIL sweep_step0_hold: got %h expected 10000000", ph_log[21]); else pass_cnt++;
    total_cnt++; if (ph_log[22] !== 32'h0 || idx_log[22] !== 16'd1) $display("FAIL sweep_step1: got %h idx %0d expected 00000000 idx 1", ph_log[22], idx_log[22]); else pass_cnt++;
    total_cnt++; if (ph_log[44] !== 32'hF000_0000 || idx_log[44] !== 16'd2) $display("FAIL sweep_step2: got %h idx %0d expected f0000000 idx 2", ph_log[44], idx_log[44]); else pass_cnt++;
    total_cnt++; if (count_valid(0, 80) != 12) $display("FAIL sweep_valid_cnt: got %0d expected 12", count_valid(0, 80)); else pass_cnt++;
    total_cnt++; if (count_done(0, 80) != 1 || done_log[66] !== 1'b1) $display("FAIL sweep_done: got %0d pulses (@66=%0d) expected 1", count_done(0, 80), done_log[66]); else pass_cnt++;
    total_cnt++; if (busy_log[66] !== 1'b1 || busy_log[67] !== 1'b0) $display("FAIL sweep_busy_end: got %0d%0d expected 10", busy_log[66], busy_log[67]); else pass_cnt++;
  endtask

  task automatic test_degenerate_back_to_back();
    f_start = 32'h0000_0100; f_step = 32'h0; amp = 16'd5; n_steps = 16'd0; dwell = 16'd0;
    pulse_start();
    rec(0);
    for (int e = 1; e <= 21; e++) begin
      if (e == 20) start = 1'b1;
      tick();
      rec(e);
    end
    start = 1'b0;
    total_cnt++; if (count_valid(0, 21) != 1 || val_log[19] !== 1'b1) $display("FAIL degen_valid: got %0d expected 1", count_valid(0, 21)); else pass_cnt++;
    total_cnt++; if (count_done(0, 21) != 1 || done_log[19] !== 1'b1) $display("FAIL degen_done: got %0d (@19=%0d) expected 1", count_done(0, 21), done_log[19]); else pass_cnt++;
    total_cnt++; if (busy_log[20] !== 1'b0 || xin_log[20] !== '0) $display("FAIL b2b_start_in_done: got busy=%0d xin=%0d expected 0/0", busy_log[20], xin_log[20]); else pass_cnt++;
    total_cnt++; if (busy_log[21] !== 1'b1 || xin_log[21] !== 16'd5) $display("FAIL b2b_restart: got busy=%0d xin=%0d expected 1/5", busy_log[21], xin_log[21]); else pass_cnt++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    f_start = 32'h1000_0000; f_step = 32'h1000_0000; amp = 16'd100; n_steps = 16'd3; dwell = 16'd4;
    pulse_start();
    rec(0);
    for (int e = 1; e <= 25; e++) begin tick(); rec(e); end
    total_cnt++; if (step_idx !== 16'd1 || phase_step !== 32'h2000_0000) $display("FAIL abort_pre: got idx %0d phase %h expected 1/20000000", step_idx, phase_step); else pass_cnt++;
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0;
    total_cnt++; if (busy !== 1'b0 || phase_step !== '0 || xin !== '0 || step_idx !== '0) $display("FAIL abort_settle: got busy=%0d ph=%h xin=%0d idx=%0d expected all 0", busy, phase_step, xin, step_idx); else pass_cnt++;
    total_cnt++; if (done !== 1'b0 || count_done(0, 25) != 0) $display("FAIL abort_no_done: got %0d expected 0", done); else pass_cnt++;
    tick();
    start = 1'b0;
    total_cnt++; if (busy !== 1'b1 || phase_step !== 32'h1000_0000 || xin !== 16'd100) $display("FAIL abort_restart: got busy=%0d ph=%h xin=%0d expected 1/10000000/100", busy, phase_step, xin); else pass_cnt++;
    for (int e = 1; e <= 20; e++) tick();
    total_cnt++; if (iq_valid !== 1'b1) $display("FAIL abort_dwell_pre: got valid=%0d expected 1", iq_valid); else pass_cnt++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total_cnt++; if (busy !== 1'b0 || iq_valid !== 1'b1) $display("FAIL abort_dwell_pipe: got busy=%0d valid=%0d expected 0/1", busy, iq_valid); else pass_cnt++;
    tick();
    total_cnt++; if (iq_valid !== 1'b0) $display("FAIL abort_dwell_drop: got valid=%0d expected 0", iq_valid); else pass_cnt++;
  endtask

`ifdef SWEEP_LOOP_EN
  task automatic test_loop();
    f_start = 32'h0400_0000; f_step = 32'h0200_0000; amp = 16'd77; n_steps = 16'd2; dwell = 16'd2;
    loop = 1'b1;
    pulse_start();
    rec(0);
    for (int e = 1; e <= 125; e++) begin
      if (e == 100) loop = 1'b0;
      tick();
      rec(e);
    end
    total_cnt++; if (ph_log[20] !== 32'h0600_0000 || idx_log[20] !== 16'd1) $display("FAIL loop_step1: got %h idx %0d expected 06000000 idx 1", ph_log[20], idx_log[20]); else pass_cnt++;
    total_cnt++; if (ph_log[40] !== 32'h0400_0000 || idx_log[40] !== 16'd0) $display("FAIL loop_wrap_phase: got %h idx %0d expected 04000000 idx 0", ph_log[40], idx_log[40]); else pass_cnt++;
    total_cnt++; if (count_done(0, 125) != 3 || done_log[40] !== 1'b1 || done_log[80] !== 1'b1 || done_log[120] !== 1'b1) $display("FAIL loop_done_period: got %0d pulses expected 3 at 40/80/120", count_done(0, 125)); else pass_cnt++;
    total_cnt++; if (xin_log[41] !== 16'd77 || busy_log[41] !== 1'b1) $display("FAIL loop_xin_hold: got xin=%0d busy=%0d expected 77/1", xin_log[41], busy_log[41]); else pass_cnt++;
    total_cnt++; if (busy_log[121] !== 1'b0 || xin_log[121] !== '0) $display("FAIL loop_exit: got busy=%0d xin=%0d expected 0/0", busy_log[121], xin_log[121]); else pass_cnt++;
  endtask
`endif

  task automatic test_reset_mid_dwell();
    xout_c = 22'h12345; yout_c = 22'h0ABCD;
    f_start = 32'h0123_4567; f_step = 32'h0; amp = 16'd321; n_steps = 16'd1; dwell = 16'd8;
    pulse_start();
    for (int e = 1; e <= 20; e++) tick();
    total_cnt++; if (busy !== 1'b1 || iq_valid !== 1'b1 || i_out !== 22'h12345) $display("FAIL rst_mid_pre: got busy=%0d valid=%0d i=%h expected 1/1/12345", busy, iq_valid, i_out); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (busy !== 1'b0 || phase_step !== '0 || xin !== '0 || step_idx !== '0) $display("FAIL rst_mid_ctrl: got busy=%0d ph=%h xin=%0d idx=%0d expected all 0", busy, phase_step, xin, step_idx); else pass_cnt++;
    total_cnt++; if (iq_valid !== 1'b0 || i_out !== '0 || q_out !== '0 || done !== 1'b0) $display("FAIL rst_mid_out: got valid=%0d i=%h q=%h done=%0d expected all 0", iq_valid, i_out, q_out, done); else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
    tick();
    total_cnt++; if (busy !== 1'b0 || xin !== '0) $display("FAIL rst_mid_idle: got busy=%0d xin=%0d expected 0/0", busy, xin); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; loop = 1'b0;
    f_start = '0; f_step = '0; n_steps = '0; dwell = '0; amp = '0;
    xout_c = '0; yout_c = '0;
    test_reset();
    test_output_stage();
    test_single_tone();
    test_three_step();
    test_degenerate_back_to_back();
    test_abort();
`ifdef SWEEP_LOOP_EN
    test_loop();
`endif
    test_reset_mid_dwell();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
